spart_tx_arbiter: RTL and testbench

//   Shares the single SPART transmitter among NREQ byte producers. Round-robin

---
 rtl/spart_tx_arbiter_if.sv | 28 ++
 rtl/spart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_spart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/spart_tx_arbiter_if.sv
// Requester-side and SPART-side signals of the shared transmitter arbiter.
// The master modport is the arbiter; slave is the surrounding environment.
interface spart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned DW = 8;
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      tx_data;
  logic               tx_start;
  logic               tx_ready;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               to_err;

  modport master (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_data, tx_start, grant_id, busy, to_err
  );

  modport slave (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_data, tx_start, grant_id, busy, to_err
  );
endinterface

// File: rtl/spart_tx_arbiter.sv
// Round-robin arbiter sharing one SPART transmitter among NREQ byte producers,
// with a start timeout in case the SPART never leaves its idle state.
module spart_tx_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned TO_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  spart_tx_arbiter_if.master bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
  localparam logic [GW-1:0] LAST_ID = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_ptr, w_ptr_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [DW-1:0]   r_tx_data, w_tx_data_nxt;
  logic [GW-1:0]   r_grant_id, w_grant_id_nxt;
  logic [NREQ-1:0] r_req_ready, w_req_ready_nxt;
  logic            r_tx_start, w_tx_start_nxt;
  logic            r_to_err, w_to_err_nxt;
  logic            r_busy, w_busy_nxt;

  logic [DW-1:0]   w_bytes [NREQ];
  logic [GW-1:0]   w_idx;
  logic [GW-1:0]   w_winner;
  logic            w_found;

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign w_bytes[g] = bus.req_data[g*DW +: DW];
  end

  // First asserted requester scanning from the round-robin pointer upwards.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = GW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_timer_nxt     = r_timer;
    w_tx_data_nxt   = r_tx_data;
    w_grant_id_nxt  = r_grant_id;
    w_req_ready_nxt = '0;
    w_tx_start_nxt  = 1'b0;
    w_to_err_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.tx_ready && w_found) begin
          w_tx_data_nxt   = w_bytes[w_winner];
          w_grant_id_nxt  = w_winner;
          w_req_ready_nxt = NREQ'(1) << w_winner;
          w_ptr_nxt       = (w_winner == LAST_ID) ? '0 : w_winner + GW'(1);
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_tx_start_nxt = 1'b1;
        w_timer_nxt    = '0;
        w_state_nxt    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // The byte is abandoned on timeout; the pointer already moved past it.
        if (!bus.tx_ready) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_timer == TO_LAST) begin
          w_to_err_nxt = 1'b1;
          w_timer_nxt  = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_timer     <= '0;
      r_tx_data   <= '0;
      r_grant_id  <= '0;
      r_req_ready <= '0;
      r_tx_start  <= 1'b0;
      r_to_err    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_timer     <= w_timer_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_to_err    <= w_to_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_start  = r_tx_start;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = r_busy;
  assign bus.to_err    = r_to_err;
endmodule

// File: tb/tb_spart_tx_arbiter.sv
// Directed bench for spart_tx_arbiter: single grant, fairness, wrap, timeout,
// blocked SPART and reset mid-frame, against hand-computed expectations.
module tb_spart_tx_arbiter;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned TO_CYC = 16;
  localparam int          BUSY_CYC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic auto_mode = 1'b0;
  logic man_ready = 1'b1;
  logic model_ready = 1'b1;
  int   model_cnt = 0;
  int   n_chk = 0;
  int   n_err = 0;

  spart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  spart_tx_arbiter #(.NREQ(NREQ), .TO_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.tx_ready = auto_mode ? model_ready : man_ready;

  // SPART model: goes busy the cycle after tx_start, for BUSY_CYC cycles.
  always @(posedge clk) begin
    if (rst) begin
      model_ready <= 1'b1;
      model_cnt   <= 0;
    end else if (auto_mode && bus.tx_start) begin
      model_ready <= 1'b0;
      model_cnt   <= BUSY_CYC;
    end else if (model_cnt > 1) begin
      model_cnt <= model_cnt - 1;
    end else if (model_cnt == 1) begin
      model_cnt   <= 0;
      model_ready <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    bus.req_data[i*8 +: 8] = b;
  endtask

  // Wait for a grant, check it, withdraw the requesters in clr, check tx_start.
  task automatic do_frame(input int exp_id, input logic [7:0] exp_data, input logic [3:0] clr);
    int lat;
    logic got;
    logic [3:0] exp_oh;
    lat = 0;
    got = 1'b0;
    exp_oh = 4'(1 << exp_id);
    for (int i = 0; i < 20 && !got; i++) begin
      step(1);
      lat++;
      if (bus.req_ready != '0) got = 1'b1;
    end
    chk("rdy_seen", 32'(got), 32'd1);
    chk("rdy_lat", 32'(lat), 32'd1);
    chk("rdy_oh", 32'(bus.req_ready), 32'(exp_oh));
    chk("grant_id", 32'(bus.grant_id), 32'(exp_id));
    chk("tx_data", 32'(bus.tx_data), 32'(exp_data));
    chk("start_early", 32'(bus.tx_start), 32'd0);
    bus.req_valid = bus.req_valid & ~clr;
    step(1);
    chk("tx_start", 32'(bus.tx_start), 32'd1);
    chk("rdy_pulse", 32'(bus.req_ready), 32'd0);
  endtask

  // Wait for the frame to finish; no further tx_start may appear meanwhile.
  task automatic wait_idle();
    logic done;
    int nstart;
    done = 1'b0;
    nstart = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1);
      if (bus.tx_start) nstart++;
      if (!bus.busy) done = 1'b1;
    end
    chk("idle_reached", 32'(done), 32'd1);
    chk("extra_start", 32'(nstart), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstart;
    int nbusy;
    bus.req_valid = '0;
    bus.req_data  = '0;
    rst = 1'b1;
    step(3);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rdy", 32'(bus.req_ready), 32'd0);
    chk("rst_start", 32'(bus.tx_start), 32'd0);
    chk("rst_data", 32'(bus.tx_data), 32'd0);
    chk("rst_gid", 32'(bus.grant_id), 32'd0);
    chk("rst_toerr", 32'(bus.to_err), 32'd0);
    rst = 1'b0;
    step(1);

    // Fairness: all four valid, strict rotation 0,1,2,3,0.
    auto_mode = 1'b1;
    for (int i = 0; i < 4; i++) set_byte(i, 8'(8'h10 + 8'h11 * i));
    bus.req_valid = 4'b1111;
    do_frame(0, 8'h10, 4'b0000); wait_idle();
    do_frame(1, 8'h21, 4'b0000); wait_idle();
    do_frame(2, 8'h32, 4'b0000); wait_idle();
    do_frame(3, 8'h43, 4'b0000); wait_idle();
    do_frame(0, 8'h10, 4'b1111); wait_idle();

    // Single requester 2.
    set_byte(2, 8'hA5);
    bus.req_valid = 4'b0100;
    do_frame(2, 8'hA5, 4'b0100); wait_idle();

    // Wrap: pointer at 3, requesters 3 and 0.
    set_byte(3, 8'h3C);
    set_byte(0, 8'hC0);
    bus.req_valid = 4'b1001;
    do_frame(3, 8'h3C, 4'b1000); wait_idle();
    do_frame(0, 8'hC0, 4'b0001); wait_idle();

    // Timeout: pointer now 1, so requester 1 beats 0; SPART never drops ready.
    auto_mode = 1'b0;
    man_ready = 1'b1;
    set_byte(0, 8'h77);
    set_byte(1, 8'h88);
    bus.req_valid = 4'b0011;
    do_frame(1, 8'h88, 4'b0010);
    step(TO_CYC - 1);
    chk("to_err_early", 32'(bus.to_err), 32'd0);
    chk("to_busy_pre", 32'(bus.busy), 32'd1);
    step(1);
    chk("to_err", 32'(bus.to_err), 32'd1);
    chk("to_busy", 32'(bus.busy), 32'd0);
    chk("to_nostart", 32'(bus.tx_start), 32'd0);
    step(1);
    chk("to_err_pulse", 32'(bus.to_err), 32'd0);
    chk("to_next_rdy", 32'(bus.req_ready), 32'h1);
    chk("to_next_data", 32'(bus.tx_data), 32'h77);
    bus.req_valid = 4'b0000;
    step(1);
    chk("to_next_start", 32'(bus.tx_start), 32'd1);
    man_ready = 1'b0;
    step(2);
    man_ready = 1'b1;
    wait_idle();

    // Blocked: SPART not ready, no grant until it is.
    man_ready = 1'b0;
    set_byte(0, 8'h5A);
    bus.req_valid = 4'b0001;
    step(4);
    chk("blk_rdy", 32'(bus.req_ready), 32'd0);
    chk("blk_busy", 32'(bus.busy), 32'd0);
    man_ready = 1'b1;
    step(1);
    chk("blk_grant", 32'(bus.req_ready), 32'h1);
    chk("blk_data", 32'(bus.tx_data), 32'h5A);
    bus.req_valid = 4'b0000;
    step(1);
    chk("blk_start", 32'(bus.tx_start), 32'd1);
    man_ready = 1'b0;
    step(2);
    man_ready = 1'b1;
    wait_idle();

    // Reset while the SPART is shifting.
    auto_mode = 1'b1;
    set_byte(2, 8'hE7);
    bus.req_valid = 4'b0100;
    do_frame(2, 8'hE7, 4'b0100);
    step(3);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step(1);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_data", 32'(bus.tx_data), 32'd0);
    chk("mrst_gid", 32'(bus.grant_id), 32'd0);
    chk("mrst_start", 32'(bus.tx_start), 32'd0);
    rst = 1'b0;
    nstart = 0;
    nbusy = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (bus.tx_start) nstart++;
      if (bus.busy) nbusy++;
    end
    chk("post_rst_start", 32'(nstart), 32'd0);
    chk("post_rst_busy", 32'(nbusy), 32'd0);

    // Pointer back at 0 after reset.
    for (int i = 0; i < 4; i++) set_byte(i, 8'(8'hB0 + i));
    bus.req_valid = 4'b1111;
    do_frame(0, 8'hB0, 4'b1111); wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
